// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply/divide: shift-add MULT, restoring DIV.
// Optional MULTDIV_EARLY_OUT_EN skips iterations for zero operands / divisor.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_UPPER,
    input  logic             ctrl_UNSIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_mag, b_mag, acc, q;
    logic [CNT_W-1:0] cnt;
    logic             sa, sb, is_div, upper, uns, skip;

    logic             start, a_neg, b_neg;
    logic [WIDTH-1:0] a_in, b_in;

    assign start = ctrl_MULT | ctrl_DIV;
    assign a_neg = ~ctrl_UNSIGNED & data_operandA[WIDTH-1];
    assign b_neg = ~ctrl_UNSIGNED & data_operandB[WIDTH-1];
    assign a_in  = a_neg ? -data_operandA : data_operandA;
    assign b_in  = b_neg ? -data_operandB : data_operandB;

    // One iteration: {acc,q} is the product register for MULT,
    // remainder/quotient pair for DIV.
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] acc_nx, q_nx;

    always_comb begin
        mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, a_mag} : '0);
        div_sh   = {acc, q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_mag};
        acc_nx   = mul_sum[WIDTH:1];
        q_nx     = {mul_sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_nx = div_diff[WIDTH-1:0];
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = div_sh[WIDTH-1:0];
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi, lo, quo, rem, fix_res;
    logic               p_neg, fix_exc;

    always_comb begin
        p_neg   = sa ^ sb;
        prod    = p_neg ? -{acc, q} : {acc, q};
        hi      = prod[2*WIDTH-1:WIDTH];
        lo      = prod[WIDTH-1:0];
        quo     = p_neg ? -q : q;
        rem     = sa ? -acc : acc;
        fix_res = upper ? hi : lo;
        fix_exc = ~upper & (uns ? (hi != '0) : (hi != {WIDTH{lo[WIDTH-1]}}));
        if (is_div) begin
            if (b_mag == '0) begin
                fix_res = '0;
                fix_exc = 1'b1;
            end else begin
                fix_res = upper ? rem : quo;
                // only MIN / -1 yields a positive quotient of 2^(WIDTH-1)
                fix_exc = ~uns & ~p_neg & q[WIDTH-1];
            end
        end
    end

`ifdef MULTDIV_EARLY_OUT_EN
    logic early;
    assign early = (a_mag == '0) | (is_div & (b_mag == '0));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (start) begin
            state          <= LOAD;
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
            a_mag          <= a_in;
            b_mag          <= b_in;
            sa             <= a_neg;
            sb             <= b_neg;
            is_div         <= ~ctrl_MULT;
            upper          <= ctrl_UPPER;
            uns            <= ctrl_UNSIGNED;
        end else begin
            unique case (state)
                IDLE: state <= IDLE;
                LOAD: begin
                    state <= RUN;
                    acc   <= '0;
                    q     <= is_div ? a_mag : b_mag;
`ifdef MULTDIV_EARLY_OUT_EN
                    // a single idle pass keeps the RDY edge at E3
                    skip  <= early;
                    cnt   <= early ? CNT_W'(1) : CNT_W'(WIDTH);
                    if (early)
                        q <= '0;
`else
                    skip  <= 1'b0;
                    cnt   <= CNT_W'(WIDTH);
`endif
                end
                RUN: begin
                    if (!skip) begin
                        acc <= acc_nx;
                        q   <= q_nx;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= FIX;
                end
                FIX: begin
                    state          <= DONE;
                    data_result    <= fix_res;
                    data_exception <= fix_exc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                end
                DONE: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed checks for multdiv_iter at WIDTH=32.
module tb_multdiv_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic        ctrl_UPPER = 1'b0;
    logic        ctrl_UNSIGNED = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef MULTDIV_EARLY_OUT_EN
    localparam int LAT_BZ = 3;
`else
    localparam int LAT_BZ = 34;
`endif

    multdiv_iter #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .ctrl_UPPER(ctrl_UPPER),
        .ctrl_UNSIGNED(ctrl_UNSIGNED),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a start pulse sampled at the next rising edge (E0).
    task automatic start_op(input logic m, input logic d, input logic up,
                            input logic un, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        ctrl_UPPER = up;
        ctrl_UNSIGNED = un;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic m, input logic up,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_r,
                      input logic exp_x, input int exp_lat);
        int lat;
        start_op(m, ~m, up, un, a, b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rdy(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, data_result, exp_r);
        chk({tag, "_exc"}, 32'(data_exception), 32'(exp_x));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, 32'(data_resultRDY), 32'd0);
        chk({tag, "_hold"}, data_result, exp_r);
    endtask

    initial begin
        int lat;
        int pulses;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_res", data_result, 32'h0);
        chk("rst_exc", 32'(data_exception), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        op("smul_lo", 1, 0, 0, -32'sd7, 32'd6, 32'hFFFFFFD6, 0, 34);
        op("umul_lo", 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1, 34);
        op("umul_hi", 1, 1, 1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 0, 34);
        op("smul_hi", 1, 1, 0, -32'sd7, 32'd6, 32'hFFFFFFFF, 0, 34);
        op("sdiv_q", 0, 0, 0, -32'sd17, 32'd5, 32'hFFFFFFFD, 0, 34);
        op("sdiv_r", 0, 1, 0, -32'sd17, 32'd5, 32'hFFFFFFFE, 0, 34);
        op("udiv_q", 0, 0, 1, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 0, 34);
        op("udiv_r", 0, 1, 1, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 0, 34);
        op("ovf_q", 0, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 34);
        op("ovf_r", 0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 34);
        op("dz_q", 0, 0, 0, 32'd123, 32'd0, 32'h0, 1, LAT_BZ);
        op("dz_r", 0, 1, 1, 32'd123, 32'd0, 32'h0, 1, LAT_BZ);

        // MULT wins when both start strobes are high
        start_op(1, 1, 0, 0, 32'd3, 32'd4);
        wait_rdy(lat);
        chk("prio_res", data_result, 32'd12);

        // abort a MULT with a DIV at E10
        pulses = 0;
        start_op(1, 0, 0, 0, 32'd3, 32'd4);
        for (int i = 1; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        start_op(0, 1, 0, 0, 32'd100, 32'd7);
        chk("abort_norpy", 32'(pulses), 32'd0);
        chk("abort_hold", data_result, 32'd12);
        wait_rdy(lat);
        chk("abort_lat", 32'(lat), 32'd34);
        chk("abort_res", data_result, 32'd14);

        // reset at E20 of a MULT
        start_op(1, 0, 0, 0, 32'd9, 32'd9);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("mrst_res", data_result, 32'h0);
        chk("mrst_exc", 32'(data_exception), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("mrst_norpy", 32'(pulses), 32'd0);
        op("post_rst", 1, 0, 0, 32'd2, 32'd3, 32'd6, 0, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
